// File: rtl/multi_ch_frame_feeder_if.sv
// Source-RAM read port and downstream FIFO write port of the frame feeder.
// The master side is the feeder; the slave side is RAM plus FIFO.
interface multi_ch_frame_feeder_if #(
    parameter int DWIDTH = 32,
    parameter int NUM_CH = 3,
    parameter int AW     = 16
);
    logic                     src_rd_en;
    logic [AW-1:0]            src_addr;
    logic [NUM_CH*DWIDTH-1:0] src_data;
    logic [NUM_CH*DWIDTH-1:0] fifo_data;
    logic                     fifo_wrreq;
    logic                     fifo_full;

    modport master (
        output src_rd_en, src_addr, fifo_data, fifo_wrreq,
        input  src_data, fifo_full
    );

    modport slave (
        input  src_rd_en, src_addr, fifo_data, fifo_wrreq,
        output src_data, fifo_full
    );
endinterface

// File: rtl/multi_ch_frame_feeder.sv
// N-channel frame source: streams NUM_PASS x NUM_IMG frames from a
// 1-cycle-latency RAM into a FIFO through a 2-entry skid buffer.
module multi_ch_frame_feeder #(
    parameter int DWIDTH   = 32,
    parameter int NUM_CH   = 3,
    parameter int WIDTH    = 224,
    parameter int HEIGHT   = 224,
    parameter int NUM_IMG  = 1,
    parameter int NUM_PASS = 1,
    parameter int AW       = $clog2(WIDTH*HEIGHT*NUM_IMG)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    multi_ch_frame_feeder_if.master      bus,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_PASS):0]    pass_idx
);
    localparam int DW = NUM_CH*DWIDTH;
    localparam int XW = $clog2(WIDTH+1);
    localparam int YW = $clog2(HEIGHT+1);
    localparam int IW = $clog2(NUM_IMG+1);
    localparam int PW = $clog2(NUM_PASS)+1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [IW-1:0] img;
    logic [PW-1:0] pass;
    logic [AW-1:0] addr;
    logic          inflight;
    logic [1:0]    cnt;
    logic [1:0]    occ;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic          rd;
    logic          wr;
    logic          x_end;
    logic          y_end;
    logic          i_end;
    logic          p_end;
    logic          last;

    assign x_end = (x == XW'(WIDTH-1));
    assign y_end = (y == YW'(HEIGHT-1));
    assign i_end = (img == IW'(NUM_IMG-1));
    assign p_end = (pass == PW'(NUM_PASS-1));
    assign last  = x_end && y_end && i_end && p_end;

    // Occupancy counts the word still in flight from the RAM, so the
    // buffer can never be asked to hold a third word.
    assign occ = cnt + {1'b0, inflight};
    assign wr  = (cnt != 2'd0) && !bus.fifo_full;
    assign rd  = (state == S_RUN) &&
                 ((occ < 2'd2) || ((occ == 2'd2) && wr));

    assign bus.src_rd_en  = rd;
    assign bus.src_addr   = addr;
    assign bus.fifo_data  = buf0;
    assign bus.fifo_wrreq = wr;
    assign busy           = (state == S_RUN) || (state == S_DRAIN);
    assign done           = (state == S_DONE);
    assign pass_idx       = pass;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (rd && last) state <= S_DRAIN;
                S_DRAIN: begin
                    if (!inflight &&
                        ((cnt == 2'd0) || ((cnt == 2'd1) && wr)))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            img  <= '0;
            pass <= '0;
            addr <= '0;
        end else if (rd) begin
            addr <= (x_end && y_end && i_end) ? '0 : addr + AW'(1);
            if (!x_end) begin
                x <= x + XW'(1);
            end else begin
                x <= '0;
                if (!y_end) begin
                    y <= y + YW'(1);
                end else begin
                    y <= '0;
                    if (!i_end) begin
                        img <= img + IW'(1);
                    end else begin
                        img  <= '0;
                        pass <= p_end ? '0 : pass + PW'(1);
                    end
                end
            end
        end
    end

    // Skid buffer: buf0 is the head presented to the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            cnt      <= 2'd0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            inflight <= rd;
            unique case ({inflight, wr})
                2'b10: begin
                    if (cnt == 2'd0) buf0 <= bus.src_data;
                    else             buf1 <= bus.src_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        buf0 <= bus.src_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bus.src_data;
                    end
                end
                2'b00: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_ch_frame_feeder.sv
// Randomized bench for multi_ch_frame_feeder against a word-level
// model of read issue, buffering, write order and run timing.
module tb_multi_ch_frame_feeder;
    localparam int DWIDTH   = 8;
    localparam int NUM_CH   = 3;
    localparam int WIDTH    = 4;
    localparam int HEIGHT   = 2;
    localparam int NUM_IMG  = 2;
    localparam int NUM_PASS = 2;
    localparam int N   = WIDTH*HEIGHT*NUM_IMG;
    localparam int TOT = N*NUM_PASS;
    localparam int AW  = $clog2(N);
    localparam int DW  = NUM_CH*DWIDTH;
    localparam int PW  = $clog2(NUM_PASS)+1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass_idx;
    logic          full = 1'b0;
    logic [DW-1:0] ram_q = '0;

    bit full_hold = 0;
    bit bp_rand   = 0;
    bit no_bp     = 0;

    int checks = 0;
    int errors = 0;

    multi_ch_frame_feeder_if #(
        .DWIDTH(DWIDTH), .NUM_CH(NUM_CH), .AW(AW)
    ) bus ();

    multi_ch_frame_feeder #(
        .DWIDTH(DWIDTH), .NUM_CH(NUM_CH), .WIDTH(WIDTH),
        .HEIGHT(HEIGHT), .NUM_IMG(NUM_IMG), .NUM_PASS(NUM_PASS),
        .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass_idx(pass_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(int a);
        logic [DW-1:0] w;
        for (int c = 0; c < NUM_CH; c++)
            w[c*DWIDTH +: DWIDTH] = DWIDTH'(a + 64*c);
        return w;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    assign bus.src_data  = ram_q;
    assign bus.fifo_full = full;

    always @(posedge clk)
        if (bus.src_rd_en) ram_q <= word(int'(bus.src_addr));

    always @(posedge clk) begin
        #1;
        full = bp_rand ? 1'($urandom_range(0, 1)) : full_hold;
    end

    // Model: reads and writes counted in word units, data visible two
    // cycles after its read, run ends the cycle after the last write.
    int reads = 0, wcnt = 0, arrived = 0, cyc = 0;
    bit d1 = 0, d2 = 0, eb = 0, ed = 0;

    always @(negedge clk) begin
        bit nb, nd, valid;
        if (reset) begin
            reads = 0; wcnt = 0; arrived = 0; cyc = 0;
            d1 = 0; d2 = 0; eb = 0; ed = 0;
        end else begin
            cyc++;
            nb = eb;
            nd = 0;
            chk("busy", busy, eb);
            chk("done", done, ed);
            if (d2) arrived++;
            if (no_bp && eb) chk("rd_rate", bus.src_rd_en, reads < TOT);
            if (bus.src_rd_en) begin
                chk("rd_in_run", eb && reads < TOT, 1);
                chk("addr", bus.src_addr, reads % N);
                chk("pass_idx", pass_idx, reads / N);
                chk("outstanding",
                    (reads + 1 - (wcnt + int'(bus.fifo_wrreq))) <= 2, 1);
                reads++;
            end
            valid = arrived > wcnt;
            chk("wrreq", bus.fifo_wrreq, valid && !full);
            if (valid) chk("data", bus.fifo_data, word(wcnt % N));
            if (bus.fifo_wrreq) begin
                if (wcnt == 0 && no_bp) chk("first_wr_cyc", cyc, 3);
                wcnt++;
                if (wcnt == TOT) begin
                    nb = 0;
                    nd = 1;
                    if (no_bp) chk("done_cyc", cyc + 1, TOT + 3);
                end
            end
            d2 = d1;
            d1 = bus.src_rd_en;
            if (start && !eb && !ed) begin
                nb = 1;
                reads = 0; wcnt = 0; arrived = 0; cyc = 0;
                d1 = 0; d2 = 0;
            end
            eb = nb;
            ed = nd;
        end
    end

    task automatic pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic run(bit mid);
        pulse();
        if (mid) begin
            repeat (8) @(posedge clk);
            #1;
            pulse();
        end
        wait_done();
        chk("words", wcnt, TOT);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd"}, bus.src_rd_en, 0);
        chk({tag, "_wr"}, bus.fifo_wrreq, 0);
        chk({tag, "_data"}, bus.fifo_data, 0);
        chk({tag, "_addr"}, bus.src_addr, 0);
        chk({tag, "_pass"}, pass_idx, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 chk_zero("rst");
        @(posedge clk); #1 reset = 1'b0;

        no_bp = 1;
        run(0);
        no_bp = 0;

        bp_rand = 1;
        run(0);
        bp_rand = 0;

        full_hold = 1;
        repeat (2) @(posedge clk);
        pulse();
        repeat (20) @(posedge clk);
        #1;
        chk("hold_reads", reads, 2);
        chk("hold_writes", wcnt, 0);
        full_hold = 0;
        wait_done();
        chk("hold_words", wcnt, TOT);

        pulse();
        n = 0;
        while (wcnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_writes", wcnt >= 5, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("async");
        @(posedge clk); #1 reset = 1'b0;
        bp_rand = 1;
        run(0);
        bp_rand = 0;

        no_bp = 1;
        run(1);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("done_start_ign", busy, 0);
        run(0);
        no_bp = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
